// File: rtl/sram_pkg.sv
// Shared defaults, types and clear-FSM state encoding for the SRAM responder.
package sram_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_CNT_W-1:0]  cnt_t;

    typedef enum logic {
        CLR_CLEAR = 1'b0,
        CLR_IDLE  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/sram_rd_pipe.sv
// RD_LAT-deep {valid, data} shift register; each stage's data only moves with a
// valid, so the last stage holds the most recent read data between pulses.
module sram_rd_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [RD_LAT-1:0] v_q;
    logic [DATA_W-1:0] d_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= in_valid_i;
            if (in_valid_i) begin
                d_q[0] <= in_data_i;
            end
            for (int i = 1; i < int'(RD_LAT); i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    d_q[i] <= d_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = v_q[RD_LAT-1];
    assign out_data_o  = d_q[RD_LAT-1];

endmodule

// File: rtl/sram_responder.sv
// Slave end of the CPU-to-SRAM interface: on-chip array, fixed-latency reads,
// request counters and sticky range error. SRAM_CLEAR_EN adds a zero-fill FSM.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sram_rd,
    input  logic [ADDR_W-1:0] sram_raddr,
    output logic [DATA_W-1:0] sram_rd_data,
    output logic              sram_rd_valid,
    input  logic              sram_wr,
    input  logic [ADDR_W-1:0] sram_waddr,
    input  logic [DATA_W-1:0] sram_wr_data,
    output logic              sram_ready,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              addr_err
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("sram_responder: RD_LAT must be in 1..4");
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("sram_responder: DEPTH exceeds address space");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_acc, wr_acc;
    logic              rd_in_range, wr_in_range;
    logic [IDX_W-1:0]  ridx, widx;
    logic              bypass;
    logic [DATA_W-1:0] rd_data0;
    logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;
    logic              addr_err_q;

    assign rd_acc      = sram_rd & sram_ready;
    assign wr_acc      = sram_wr & sram_ready;
    assign rd_in_range = {1'b0, sram_raddr} < DEPTH_L;
    assign wr_in_range = {1'b0, sram_waddr} < DEPTH_L;
    assign ridx        = IDX_W'(sram_raddr);
    assign widx        = IDX_W'(sram_waddr);
    assign bypass      = wr_acc && wr_in_range && (sram_waddr == sram_raddr);

    // Stage 0 sample: out-of-range reads return zero, same-address write wins.
    always_comb begin
        rd_data0 = '0;
        if (rd_in_range) begin
            rd_data0 = bypass ? sram_wr_data : mem[ridx];
        end
    end

`ifdef SRAM_CLEAR_EN
    clr_state_e       state_q;
    logic [IDX_W-1:0] clr_addr_q;
    logic             ready_q;
    logic             clr_we;

    // Zero-fill every word once after reset, then accept requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR_CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                CLR_CLEAR: begin
                    if (clr_addr_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= CLR_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                CLR_IDLE: ready_q <= 1'b1;
                default: begin
                    state_q <= CLR_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we     = (state_q == CLR_CLEAR);
    assign sram_ready = ready_q;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_acc && wr_in_range) begin
            mem[widx] <= sram_wr_data;
        end
    end
`else
    assign sram_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (wr_acc && wr_in_range) begin
            mem[widx] <= sram_wr_data;
        end
    end
`endif

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_acc),
        .in_data_i   (rd_data0),
        .out_valid_o (sram_rd_valid),
        .out_data_o  (sram_rd_data)
    );

    // Saturating request counters and sticky range error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (rd_acc && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (wr_acc && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if ((rd_acc && !rd_in_range) || (wr_acc && !wr_in_range)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder (DEPTH=200, RD_LAT=2); covers SRAM_CLEAR_EN too.
module tb_sram_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 200;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned CNT_W  = 16;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              sram_rd;
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] sram_rd_data;
    logic              sram_rd_valid;
    logic              sram_wr;
    logic [ADDR_W-1:0] sram_waddr;
    logic [DATA_W-1:0] sram_wr_data;
    logic              sram_ready;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic              addr_err;

    int   cyc;
    int   n_vec;
    int   n_err;
    int   rd_base;
    exp_t exp_q[$];
    exp_t mon_e;

    sram_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sram_rd       (sram_rd),
        .sram_raddr    (sram_raddr),
        .sram_rd_data  (sram_rd_data),
        .sram_rd_valid (sram_rd_valid),
        .sram_wr       (sram_wr),
        .sram_waddr    (sram_waddr),
        .sram_wr_data  (sram_wr_data),
        .sram_ready    (sram_ready),
        .rd_cnt        (rd_cnt),
        .wr_cnt        (wr_cnt),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per valid pulse; flag stray or late pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sram_rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected_valid", {31'b0, sram_rd_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rd_data", sram_rd_data, mon_e.data);
                    check("rd_cycle", 32'(cyc), 32'(mon_e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                mon_e = exp_q.pop_front();
                check("rd_missing_valid", {31'b0, sram_rd_valid}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cyc(input logic rd, input logic [7:0] ra, input logic wr,
                          input logic [7:0] wa, input logic [31:0] wd, input logic [31:0] exp_rd);
        sram_rd      = rd;
        sram_raddr   = ra;
        sram_wr      = wr;
        sram_waddr   = wa;
        sram_wr_data = wd;
        if (rd) exp_q.push_back('{data: exp_rd, due: cyc + int'(RD_LAT)});
        tick();
    endtask

    task automatic idle(input int n);
        sram_rd = 1'b0;
        sram_wr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, {31'b0, sram_rd_valid}, 32'd0);
        check({tag, "_rd_data"},  sram_rd_data, 32'd0);
        check({tag, "_rd_cnt"},   32'(rd_cnt), 32'd0);
        check({tag, "_wr_cnt"},   32'(wr_cnt), 32'd0);
        check({tag, "_addr_err"}, {31'b0, addr_err}, 32'd0);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rd_base      = 0;
        rst_n        = 1'b0;
        sram_rd      = 1'b0;
        sram_raddr   = '0;
        sram_wr      = 1'b0;
        sram_waddr   = '0;
        sram_wr_data = '0;
        tick();
        tick();
        check_reset_outputs("reset");
`ifdef SRAM_CLEAR_EN
        check("reset_ready", {31'b0, sram_ready}, 32'd0);
`else
        check("reset_ready", {31'b0, sram_ready}, 32'd1);
`endif
        rst_n = 1'b1;

`ifdef SRAM_CLEAR_EN
        begin
            int n;
            n = 0;
            sram_wr      = 1'b1;
            sram_waddr   = 8'd2;
            sram_wr_data = 32'hDEAD_BEEF;
            while (!sram_ready && n < 1000) begin
                tick();
                n++;
            end
            sram_wr = 1'b0;
            check("clear_latency", 32'(n), 32'(DEPTH));
            check("clear_wr_cnt", 32'(wr_cnt), 32'd0);
            do_cyc(1'b1, 8'd2, 1'b0, 8'd0, 32'd0, 32'd0);
            do_cyc(1'b1, 8'd199, 1'b0, 8'd0, 32'd0, 32'd0);
            idle(4);
            rd_base = 2;
        end
`endif

        // Plain write then read.
        do_cyc(1'b0, 8'd0, 1'b1, 8'd11, 32'd10, 32'd0);
        do_cyc(1'b1, 8'd11, 1'b0, 8'd0, 32'd0, 32'd10);
        idle(3);
        check("a_wr_cnt", 32'(wr_cnt), 32'd1);
        check("a_rd_cnt", 32'(rd_cnt), 32'(rd_base + 1));

        // Same-cycle bypass, then an in-flight write must not disturb it.
        do_cyc(1'b1, 8'd15, 1'b1, 8'd15, 32'hA5, 32'hA5);
        do_cyc(1'b0, 8'd0, 1'b1, 8'd15, 32'h5A, 32'd0);
        do_cyc(1'b1, 8'd15, 1'b0, 8'd0, 32'd0, 32'h5A);
        idle(3);

        // Preload addr*3 and read back-to-back.
        for (int i = 0; i < 8; i++) do_cyc(1'b0, 8'd0, 1'b1, 8'(i), 32'(i * 3), 32'd0);
        for (int i = 0; i < 8; i++) do_cyc(1'b1, 8'(i), 1'b0, 8'd0, 32'd0, 32'(i * 3));
        idle(4);
        check("c_wr_cnt", 32'(wr_cnt), 32'd11);
        check("c_rd_cnt", 32'(rd_cnt), 32'(rd_base + 11));

        // Out-of-range read and write.
        check("d_addr_err_pre", {31'b0, addr_err}, 32'd0);
        do_cyc(1'b1, 8'd250, 1'b0, 8'd0, 32'd0, 32'd0);
        check("d_addr_err_rd", {31'b0, addr_err}, 32'd1);
        do_cyc(1'b0, 8'd0, 1'b1, 8'd220, 32'h1234, 32'd0);
        idle(5);
        check("d_addr_err_hold", {31'b0, addr_err}, 32'd1);
        do_cyc(1'b1, 8'd7, 1'b0, 8'd0, 32'd0, 32'd21);
        idle(3);

        // Reset with reads in flight.
        do_cyc(1'b1, 8'd3, 1'b0, 8'd0, 32'd0, 32'd9);
        do_cyc(1'b1, 8'd4, 1'b0, 8'd0, 32'd0, 32'd12);
        sram_rd = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        idle(6);
        check_reset_outputs("postrst");

        begin
            int w;
            w = 0;
            while (exp_q.size() != 0 && w < 50) begin
                tick();
                w++;
            end
            check("sb_drain", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Slave end of the CPU-to-SRAM interface. It answers the CPU's read and write requests (sram_raddr, sram_waddr, sram_wr, sram_wr_data) from an on-chip memory array.
- Read data returns after a fixed latency. Synthesizable; sits between the CPU core and the top level, and replaces the behavioural memory in the CPU test bench.
- Also tracks request counts and a sticky range-error flag for the bench.

Parameters:
- ADDR_W, 8, address width of sram_raddr and sram_waddr.
- DATA_W, 32, data width.
- DEPTH, 256, number of words. Must be ≤ 2**ADDR_W.
- RD_LAT, 1, read latency in cycles. Legal range 1..4; elaboration $error outside that range.
- CNT_W, 16, width of the request counters.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sram_rd  in  1  read request strobe, one cycle per request.
- sram_raddr  in  ADDR_W  read address.
- sram_rd_data  out  DATA_W  read data, held until the next valid.
- sram_rd_valid  out  1  one-cycle pulse, sram_rd_data is valid.
- sram_wr  in  1  write strobe.
- sram_waddr  in  ADDR_W  write address.
- sram_wr_data  in  DATA_W  write data.
- sram_ready  out  1  block accepts requests.
- rd_cnt  out  CNT_W  accepted reads, saturating.
- wr_cnt  out  CNT_W  accepted writes, saturating.
- addr_err  out  1  sticky flag, an out-of-range address was seen.

Behaviour:
- Reset values: sram_rd_data=0, sram_rd_valid=0, rd_cnt=0, wr_cnt=0, addr_err=0. sram_ready=1, or 0 under SRAM_CLEAR_EN. The read pipeline is flushed. Array contents are not reset.
- Request acceptance: a request is accepted when its strobe is high in the same cycle that sram_ready=1. Requests made while sram_ready=0 are dropped and not counted.
- Write: an accepted write with sram_waddr<DEPTH updates mem[sram_waddr] at the clock edge. If sram_waddr≥DEPTH, the write is dropped and addr_err is set.
- Read capture:
  - An accepted read samples the array at cycle T (stage 0).
  - sram_rd_valid is asserted at T+RD_LAT, with the data sampled at T.
  - Back-to-back reads every cycle are allowed; throughput is 1/cycle.
- Read/write collision:
  - Same cycle, same address: the read returns sram_wr_data (write-first bypass).
  - A write to the same address after stage 0 does not alter in-flight data.
- Out-of-range read: sram_raddr≥DEPTH still produces a valid pulse at T+RD_LAT, with data=0, and sets addr_err.
- Counters: increment per accepted request and saturate at all-ones, with no wrap. A simultaneous read and write increment both counters.
- addr_err: cleared only by reset.
- Reset mid-operation: in-flight reads are discarded and no valid is asserted after reset is released.

Optional Feature:
- Macro SRAM_CLEAR_EN.
- Defined:
  - After reset release, a two-state FSM runs: CLEAR then IDLE.
  - In CLEAR, the FSM writes 0 to addresses 0..DEPTH-1, one per cycle, and sram_ready=0.
  - It enters IDLE after address DEPTH-1, sram_ready rises, and the total latency is DEPTH cycles.
  - Clear writes do not count in wr_cnt.
- Undefined: no FSM. sram_ready is tied to 1 and array contents are undefined (X) until written.

Decomposition:
- Package sram_pkg holds the ADDR_W, DATA_W and DEPTH defaults, the typedefs addr_t, data_t and cnt_t, and the clear FSM state enum.
- Sub-module sram_rd_pipe: an RD_LAT-deep shift register of {valid, data} with async active-low reset, instantiated once.

Test Plan:
- Write mem[11]=10 then read addr 11 at cycle T, with RD_LAT=1 → sram_rd_valid at T+1 with data=10; wr_cnt=1, rd_cnt=1.
- Same-cycle write of addr 15 with 0xA5 and read of addr 15 → returns 0xA5 (bypass). A write of 0x5A to addr 15 at T+1 with RD_LAT=3 → the T read still returns 0xA5 at T+3.
- Reads every cycle to addresses 0..7, preloaded with value=addr×3, RD_LAT=2 → eight consecutive valid pulses, data 0,3,…,21 in order.
- With DEPTH=200: read addr 250 → valid with data 0 and addr_err=1. A write to addr 220 is dropped and addr_err stays 1 until rst_n is pulsed.
- Assert rst_n=0 mid-stream with two reads in flight → no valid after release; outputs at their reset values.
- With SRAM_CLEAR_EN defined: sram_ready=0 for DEPTH cycles after reset and requests in that window are ignored. Afterwards a read of any address returns 0 and wr_cnt=0.
